ps2_receiver: RTL and testbench
===============================

# ps2_receiver

- Host-side PS/2 receiver: the listening end of the keyboard-to-host PS/2 link driven by the board's keyboard model.
- Oversamples `ps2_clk`/`ps2_dat` on `CLOCK_50` and deframes 11-bit frames: start, 8 data LSB-first, odd parity, stop.
- Emits raw scan-code bytes and, optionally, decoded key events with E0/F0 prefix handling.
- Sits between the PS/2 pins (or the keyboard model) and user logic such as HEX/LEDR display.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, 50000: `CLOCK_50` cycles without a `ps2_clk` falling edge, mid-frame, before the frame is aborted.

Ports:
- `CLOCK_50` in 1: system clock, 50 MHz.
- `resetn` in 1: reset; **one clock; reset is synchronous and active-low** (top level drives it from `KEY[0]`).
- `ps2_clk` in 1: PS/2 clock from the device; asynchronous.
- `ps2_dat` in 1: PS/2 data from the device; asynchronous.
- `rx_byte` out 8: last received data byte; holds until the next good frame.
- `byte_valid` out 1: one-cycle pulse when `rx_byte` updates.
- `parity_err` out 1: one-cycle pulse when a frame is rejected for bad parity.
- `frame_err` out 1: one-cycle pulse on a bad stop bit or a timeout.
- `key_code` out 8: decoded key code.
- `key_ext` out 1: decoded event was E0-prefixed.
- `key_break` out 1: decoded event was a release (F0-prefixed).
- `key_valid` out 1: one-cycle pulse when the `key_*` outputs update.

## Operation

Input conditioning:
- `ps2_clk` and `ps2_dat` each pass through identical 3-stage synchronizers.
- `fall` = previous synced clock is 1 and current synced clock is 0.
- Data is sampled from the synced `ps2_dat` in the same cycle as `fall`.

Frame FSM (advances only on `fall`, except for timeout):
- IDLE: on `fall` with data 0 (start bit), clear shift register and bit count, go to DATA. `fall` with data 1 is ignored and the FSM stays in IDLE.
- DATA: shift the data bit in at bit 7 (right shift, LSB-first). After the 8th bit, go to PARITY.
- PARITY: store the parity bit and go to STOP.
- STOP:
  - If stop = 1 and (XOR of the 8 data bits XOR parity) = 1: load `rx_byte`, pulse `byte_valid`.
  - Else if stop = 1 (parity wrong): pulse `parity_err` only.
  - Else (stop = 0): pulse `frame_err`; this check takes priority over parity.
  - Always return to IDLE.
- Timeout: in any state other than IDLE, an idle counter increments each cycle and resets to 0 on `fall`. When it reaches `TIMEOUT_CYCLES`, pulse `frame_err` and go to IDLE. The counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Key decoder (runs on `byte_valid`):
- Byte E0: set the ext flag; no event.
- Byte F0: set the brk flag; no event.
- Any other byte: load `key_code` = byte, `key_ext` = ext flag, `key_break` = brk flag, pulse `key_valid`, then clear both flags.
- `parity_err` or `frame_err` clears both flags.

Reset:
- All outputs 0, FSM in IDLE, counters and flags 0, synchronizer stages set to 1 (idle bus).
- A reset mid-frame discards the partial frame and produces no pulses.

## Timing

- `fall` is asserted 3 `CLOCK_50` cycles after `ps2_clk` goes low, given setup to `CLOCK_50`.
- `byte_valid`, `parity_err` and `frame_err` assert in the cycle after the stop-bit `fall`.
- `key_valid` asserts 1 cycle after `byte_valid`.
- The device must hold `ps2_clk` high and low for at least 4 `CLOCK_50` cycles each.
- `ps2_dat` must be stable from at least 1 cycle before to 1 cycle after the `ps2_clk` falling edge.
- Back-to-back frames need no gap beyond a full-length stop bit.
- All pulses are exactly one cycle wide; the error pulses and `byte_valid` are mutually exclusive.

## Configuration

- `PS2_RX_KEY_DECODE_EN` defined: the key decoder is compiled in, as described above.
- `PS2_RX_KEY_DECODE_EN` undefined: the decoder and its flags are absent. `key_code`, `key_ext`, `key_break` and `key_valid` are tied to 0. The raw byte path is unchanged.

## Test plan

- Send frame 0x1B (start 0, bits 1,1,0,1,1,0,0,0, parity 1, stop 1) → one `byte_valid`, `rx_byte`=0x1B; with decode enabled, `key_valid` the next cycle with `key_code`=0x1B, `key_ext`=0, `key_break`=0.
- Send 0xF0 then 0x1B → two `byte_valid`, one `key_valid` with `key_code`=0x1B, `key_break`=1.
- Send E0, F0, 0x75 → three `byte_valid`, one `key_valid` with `key_code`=0x75, `key_ext`=1, `key_break`=1; a following 0x1B gives `key_ext`=0, `key_break`=0.
- Send 0x1B with parity 0 → `parity_err` pulse, no `byte_valid`, `rx_byte` unchanged; then a good 0x1C → `rx_byte`=0x1C.
- With `TIMEOUT_CYCLES`=200, stop after 5 data bits and hold `ps2_clk` high → `frame_err` pulses exactly 200 cycles after the last `fall`; a following good 0x1B decodes correctly. Repeat with stop bit 0 → `frame_err` pulse, no `byte_valid`.
- Assert `resetn`=0 for one cycle mid-frame → all outputs 0, no pulses; resume clocking the remaining bits → no `byte_valid`; the next full frame 0x1B decodes correctly.

Source files
------------

// File: rtl/ps2_receiver.sv
// ps2_receiver
//
// Host-side PS/2 receiver. It oversamples ps2_clk/ps2_dat on CLOCK_50 and
// deframes 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1.
// Good frames update rx_byte and pulse byte_valid. Rejected frames pulse
// parity_err or frame_err instead.
//
// Optional feature: define PS2_RX_KEY_DECODE_EN to compile in the scan-code
// key decoder, which handles the E0 (extended) and F0 (break) prefixes. When
// the macro is undefined, key_code, key_ext, key_break and key_valid are
// tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  idle CLOCK_50 cycles allowed mid-frame before abort
//
// Ports:
//   CLOCK_50    in   system clock
//   resetn      in   synchronous active-low reset
//   ps2_clk     in   PS/2 clock from the device (asynchronous)
//   ps2_dat     in   PS/2 data from the device (asynchronous)
//   rx_byte     out  last good data byte; holds until the next good frame
//   byte_valid  out  one-cycle pulse when rx_byte updates
//   parity_err  out  one-cycle pulse when a frame fails odd parity
//   frame_err   out  one-cycle pulse on a bad stop bit or a mid-frame timeout
//   key_code    out  decoded key code
//   key_ext     out  decoded event was E0-prefixed
//   key_break   out  decoded event was a release (F0-prefixed)
//   key_valid   out  one-cycle pulse when the key_* outputs update
module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nx;
  logic [2:0]       clk_sync, dat_sync;
  logic             clk_prev;
  logic             fall, dat_bit;
  logic [7:0]       shreg, shreg_nx;
  logic [2:0]       bit_cnt, bit_cnt_nx;
  logic             par, par_nx;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;
  logic             load_byte, perr_nx, ferr_nx;

  // Both pins go through identical 3-stage synchronizers so that the data
  // sample stays aligned with the clock edge it belongs to. Resetting them
  // to 1 matches an idle bus, so reset itself never looks like an edge.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      clk_sync <= 3'b111;
      dat_sync <= 3'b111;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], ps2_dat};
      clk_prev <= clk_sync[2];
    end
  end

  assign fall    = clk_prev & ~clk_sync[2];
  assign dat_bit = dat_sync[2];

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bit_cnt_nx  = bit_cnt;
    par_nx      = par;
    idle_cnt_nx = '0;
    load_byte   = 1'b0;
    perr_nx     = 1'b0;
    ferr_nx     = 1'b0;

    if (state != IDLE) idle_cnt_nx = fall ? '0 : idle_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (fall && !dat_bit) begin
          shreg_nx   = '0;
          bit_cnt_nx = '0;
          state_nx   = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_nx   = {dat_bit, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_nx   = dat_bit;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          // A missing stop bit outranks a parity failure.
          if (!dat_bit)          ferr_nx   = 1'b1;
          else if (^{shreg, par}) load_byte = 1'b1;
          else                   perr_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort a stalled frame once the idle counter would reach TIMEOUT_CYCLES.
    if (state != IDLE && !fall && idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      ferr_nx  = 1'b1;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      idle_cnt   <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt_nx;
      par        <= par_nx;
      idle_cnt   <= idle_cnt_nx;
      if (load_byte) rx_byte <= shreg;
      byte_valid <= load_byte;
      parity_err <= perr_nx;
      frame_err  <= ferr_nx;
    end
  end

`ifdef PS2_RX_KEY_DECODE_EN
  logic ext_flag, brk_flag;

  // E0 and F0 only arm flags; the next ordinary byte consumes them.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (parity_err || frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_valid) begin
        case (rx_byte)
          8'hE0: ext_flag <= 1'b1;
          8'hF0: brk_flag <= 1'b1;
          default: begin
            key_code  <= rx_byte;
            key_ext   <= ext_flag;
            key_break <= brk_flag;
            key_valid <= 1'b1;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
          end
        endcase
      end
    end
  end
`else
  assign key_code  = '0;
  assign key_ext   = 1'b0;
  assign key_break = 1'b0;
  assign key_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver
//
// Directed-frame bench for ps2_receiver with a scoreboard. Stimulus pushes
// expected raw events (kind, byte, cycle), expected key events and expected
// output snapshots into queues; one monitor process pops and compares.
module tb_ps2_receiver;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] rx_byte;
  logic       byte_valid, parity_err, frame_err;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid;

  ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .key_valid  (key_valid)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = byte_valid, 2 = parity_err, 3 = frame_err
  typedef struct {int kind; logic [7:0] data; int cyc;} raw_t;
  typedef struct {logic [7:0] code; logic ext; logic brk;} key_t;
  typedef struct {int cyc; logic [7:0] rx; logic [7:0] kc; logic ke; logic kb;} snap_t;

  raw_t  rawq[$];
  key_t  keyq[$];
  snap_t snapq[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic bv_prev = 1'b0;
  logic done = 1'b0;
  logic done_chk = 1'b0;

  // Monitor / comparator
  always @(negedge clk) begin
    if (byte_valid || parity_err || frame_err) begin
      int ka;
      int np;
      raw_t e;
      ka = byte_valid ? 1 : (parity_err ? 2 : 3);
      np = int'(byte_valid) + int'(parity_err) + int'(frame_err);
      n_cmp++;
      if (rawq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: cycle %0d kind %0d rx_byte %02h, required no pulse", cyc, ka, rx_byte);
      end else begin
        e = rawq.pop_front();
        if (np != 1 || ka != e.kind || cyc != e.cyc || (e.kind == 1 && rx_byte != e.data)) begin
          n_bad++;
          $display("FAIL raw_event: got kind %0d (pulses %0d) byte %02h at cycle %0d, required kind %0d byte %02h at cycle %0d",
                   ka, np, rx_byte, cyc, e.kind, e.data, e.cyc);
        end
      end
    end
    if (key_valid) begin
      key_t k;
      n_cmp++;
      if (keyq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_key: cycle %0d code %02h ext %0b brk %0b, required no key_valid", cyc, key_code, key_ext, key_break);
      end else begin
        k = keyq.pop_front();
        if (!bv_prev || key_code != k.code || key_ext != k.ext || key_break != k.brk) begin
          n_bad++;
          $display("FAIL key_event: got code %02h ext %0b brk %0b after_byte_valid %0b, required code %02h ext %0b brk %0b after_byte_valid 1",
                   key_code, key_ext, key_break, bv_prev, k.code, k.ext, k.brk);
        end
      end
    end
    bv_prev = byte_valid;
    if (snapq.size() != 0 && snapq[0].cyc == cyc) begin
      snap_t s;
      s = snapq.pop_front();
      n_cmp++;
      if (rx_byte != s.rx || key_code != s.kc || key_ext != s.ke || key_break != s.kb ||
          byte_valid || parity_err || frame_err || key_valid) begin
        n_bad++;
        $display("FAIL snapshot: cycle %0d got rx %02h kc %02h ke %0b kb %0b pulses %0b%0b%0b%0b, required rx %02h kc %02h ke %0b kb %0b pulses 0000",
                 cyc, rx_byte, key_code, key_ext, key_break, byte_valid, parity_err, frame_err, key_valid,
                 s.rx, s.kc, s.ke, s.kb);
      end
    end
    if (done && !done_chk) begin
      done_chk = 1'b1;
      n_cmp++;
      if (rawq.size() != 0 || keyq.size() != 0 || snapq.size() != 0) begin
        n_bad++;
        $display("FAIL drain: outstanding raw %0d key %0d snap %0d, required 0 0 0", rawq.size(), keyq.size(), snapq.size());
      end
    end
  end

  // Drive frame bits first..last; bit 0 = start, 1..8 data LSB first, 9 parity, 10 stop.
  // When kind != 0 the expected raw event is queued as the final bit's clock drops.
  task automatic send_bits(input logic [7:0] data, input logic par, input logic stop,
                           input int first, input int last, input int kind, output int last_fall);
    logic [10:0] fr;
    fr = {stop, par, data, 1'b0};
    last_fall = 0;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      ps2_dat = fr[i];
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (i == last && kind != 0) rawq.push_back('{kind, data, cyc + 4});
      repeat (5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic good_frame(input logic [7:0] data);
    int lf;
    send_bits(data, ~^data, 1'b1, 0, 10, 1, lf);
  endtask

  task automatic expect_key(input logic [7:0] code, input logic ext, input logic brk);
`ifdef PS2_RX_KEY_DECODE_EN
    keyq.push_back('{code, ext, brk});
`endif
  endtask

  task automatic snap(input logic [7:0] rx, input logic [7:0] kc, input logic ke, input logic kb);
    @(negedge clk);
`ifdef PS2_RX_KEY_DECODE_EN
    snapq.push_back('{cyc + 1, rx, kc, ke, kb});
`else
    snapq.push_back('{cyc + 1, rx, 8'h00, 1'b0, 1'b0});
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 30000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int lf;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    snap(8'h00, 8'h00, 1'b0, 1'b0);

    // plain make code
    expect_key(8'h1B, 1'b0, 1'b0);
    good_frame(8'h1B);
    snap(8'h1B, 8'h1B, 1'b0, 1'b0);

    // break code
    expect_key(8'h1B, 1'b0, 1'b1);
    good_frame(8'hF0);
    good_frame(8'h1B);
    snap(8'h1B, 8'h1B, 1'b0, 1'b1);

    // extended break, then flags must be cleared
    expect_key(8'h75, 1'b1, 1'b1);
    good_frame(8'hE0);
    good_frame(8'hF0);
    good_frame(8'h75);
    snap(8'h75, 8'h75, 1'b1, 1'b1);
    expect_key(8'h1B, 1'b0, 1'b0);
    good_frame(8'h1B);

    // bad parity: rx_byte holds, then a good 0x1C
    send_bits(8'h1B, 1'b0, 1'b1, 0, 10, 2, lf);
    snap(8'h1B, 8'h1B, 1'b0, 1'b0);
    expect_key(8'h1C, 1'b0, 1'b0);
    good_frame(8'h1C);
    snap(8'h1C, 8'h1C, 1'b0, 1'b0);

    // timeout after 5 data bits
    send_bits(8'h1B, 1'b1, 1'b1, 0, 5, 0, lf);
    rawq.push_back('{3, 8'h00, lf + 4 + TO});
    repeat (TO + 20) @(negedge clk);
    expect_key(8'h1B, 1'b0, 1'b0);
    good_frame(8'h1B);

    // E0 then a stop-0 frame: frame_err, and the pending ext flag is dropped
    good_frame(8'hE0);
    send_bits(8'h1B, 1'b1, 1'b0, 0, 10, 3, lf);
    expect_key(8'h1B, 1'b0, 1'b0);
    good_frame(8'h1B);
    snap(8'h1B, 8'h1B, 1'b0, 1'b0);

    // one-cycle reset mid-frame, then the rest of that frame, then a good frame
    send_bits(8'h1B, 1'b1, 1'b1, 0, 8, 0, lf);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    snap(8'h00, 8'h00, 1'b0, 1'b0);
    send_bits(8'h1B, 1'b1, 1'b1, 9, 10, 0, lf);
    repeat (10) @(negedge clk);
    snap(8'h00, 8'h00, 1'b0, 1'b0);
    expect_key(8'h1B, 1'b0, 1'b0);
    good_frame(8'h1B);
    snap(8'h1B, 8'h1B, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
